// File: rtl/reg_bank_if.sv
// reg_bank_if: bundles the writeback, issue-mark, read-address and
// read-data/hazard signals of the general-purpose register bank.
// The master side (operand fetch / writeback / control) drives addresses,
// write data and strobes; the slave side (the register bank) returns
// registered read data and combinational hazard flags.
interface reg_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mark_vld;
  logic [ADDR_W-1:0] mark_addr;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              hazard_a;
  logic              hazard_b;

  modport master (
    output we, wr_addr, wr_data, mark_vld, mark_addr, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, hazard_a, hazard_b
  );

  modport slave (
    input  we, wr_addr, wr_data, mark_vld, mark_addr, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, hazard_a, hazard_b
  );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: general-purpose register bank at the consumer end of the
// writeback path. Holds NREG = 2**ADDR_W registers (all writable, no
// hardwired zero), two registered read ports and a per-register pending
// scoreboard used by the control unit to stall on read-after-write hazards.
// Optional feature macro: REG_BANK_BYPASS_EN
//   defined   -> a same-cycle write to the register being read is forwarded
//                into the read-data register (write-through)
//   undefined -> the read returns the old register contents; the new value
//                is visible one cycle later
// The scoreboard behaves identically in both builds.
module reg_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank_if.slave  bus
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   pending_q;
  logic [NREG-1:0]   pending_d;
  logic [DATA_W-1:0] rdDataA_q;
  logic [DATA_W-1:0] rdDataA_d;
  logic [DATA_W-1:0] rdDataB_q;
  logic [DATA_W-1:0] rdDataB_d;

  // Register array: reset clears everything, otherwise sink the writeback word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.we) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Scoreboard next state: clear on writeback first, then set on issue so a
  // same-address collision leaves the bit set for the newly issued producer.
  always_comb begin
    pending_d = pending_q;
    if (bus.we) begin
      pending_d[bus.wr_addr] = 1'b0;
    end
    if (bus.mark_vld) begin
      pending_d[bus.mark_addr] = 1'b1;
    end
  end

  // Scoreboard register with reset taking priority over mark and write.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Read-port next values, optionally forwarding a same-cycle write.
  always_comb begin
    rdDataA_d = regs_q[bus.rd_addr_a];
    rdDataB_d = regs_q[bus.rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
    if (bus.we && (bus.wr_addr == bus.rd_addr_a)) begin
      rdDataA_d = bus.wr_data;
    end
    if (bus.we && (bus.wr_addr == bus.rd_addr_b)) begin
      rdDataB_d = bus.wr_data;
    end
`endif
  end

  // Read-data registers give the operand fetch stage one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdDataA_q <= '0;
      rdDataB_q <= '0;
    end else begin
      rdDataA_q <= rdDataA_d;
      rdDataB_q <= rdDataB_d;
    end
  end

  assign bus.rd_data_a = rdDataA_q;
  assign bus.rd_data_b = rdDataB_q;

  // Hazards reflect the pending state before the edge; a same-cycle write
  // does not hide the hazard.
  assign bus.hazard_a = pending_q[bus.rd_addr_a];
  assign bus.hazard_b = pending_q[bus.rd_addr_b];

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed scenarios plus randomized traffic for reg_bank,
// checked against an array-based reference model of the register bank.
module tb_reg_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int NREG   = 8;

  logic clk;
  logic reset;

  reg_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  reg_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] modelRegs [NREG];
  bit          modelPend [NREG];
  int          checks;
  int          errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check hazards before the edge and read data after it.
  task automatic applyStimulus(input logic rst, input logic we, input logic [2:0] wa,
                               input logic [31:0] wd, input logic mv, input logic [2:0] ma,
                               input logic [2:0] ra, input logic [2:0] rb);
    logic [31:0] expA;
    logic [31:0] expB;
    reset         = rst;
    bus.we        = we;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.mark_vld  = mv;
    bus.mark_addr = ma;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    #1;
    checkOutput("hazard_a", {31'b0, bus.hazard_a}, {31'b0, modelPend[ra]});
    checkOutput("hazard_b", {31'b0, bus.hazard_b}, {31'b0, modelPend[rb]});
    expA = modelRegs[ra];
    expB = modelRegs[rb];
`ifdef REG_BANK_BYPASS_EN
    if (we && wa == ra) expA = wd;
    if (we && wa == rb) expB = wd;
`endif
    if (rst) begin
      expA = '0;
      expB = '0;
      for (int i = 0; i < NREG; i++) begin
        modelRegs[i] = '0;
        modelPend[i] = 1'b0;
      end
    end else begin
      if (we) begin
        modelRegs[wa] = wd;
        modelPend[wa] = 1'b0;
      end
      if (mv) modelPend[ma] = 1'b1;
    end
    @(posedge clk);
    #1;
    checkOutput("rd_data_a", bus.rd_data_a, expA);
    checkOutput("rd_data_b", bus.rd_data_b, expB);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.we = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.mark_vld = 1'b0;
    bus.mark_addr = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    for (int i = 0; i < NREG; i++) begin
      modelRegs[i] = '0;
      modelPend[i] = 1'b0;
    end
    @(posedge clk);
    #1;

    // T1: fill with ones, mark some pending, then reset and scan every address
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(1'b0, 1'b1, 3'(i), 32'hFFFF_FFFF, 1'b1, 3'(i), 3'(i), 3'(NREG - 1 - i));
    end
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd0, 3'd0);
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'(i), 3'(NREG - 1 - i));
      checkOutput("t1_rd_a", bus.rd_data_a, 32'h0);
      checkOutput("t1_rd_b", bus.rd_data_b, 32'h0);
      checkOutput("t1_hz_a", {31'b0, bus.hazard_a}, 32'h0);
    end

    // T2: write then read back on both ports
    applyStimulus(1'b0, 1'b1, 3'd5, 32'hDEAD_BEEF, 1'b0, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd5, 3'd5);
    checkOutput("t2_rd_a", bus.rd_data_a, 32'hDEAD_BEEF);
    checkOutput("t2_rd_b", bus.rd_data_b, 32'hDEAD_BEEF);

    // T3: same-cycle read and write of r3
    applyStimulus(1'b0, 1'b1, 3'd3, 32'h11, 1'b0, 3'd0, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd3, 32'h22, 1'b0, 3'd0, 3'd3, 3'd0);
`ifdef REG_BANK_BYPASS_EN
    checkOutput("t3_rd_a", bus.rd_data_a, 32'h22);
`else
    checkOutput("t3_rd_a", bus.rd_data_a, 32'h11);
`endif
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd3, 3'd3);
    checkOutput("t3_rd_later", bus.rd_data_a, 32'h22);

    // T4: mark r2 pending, then clear it with a writeback
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 3'd2, 3'd0);
    checkOutput("t4_hz_set", {31'b0, bus.hazard_a}, 32'h1);
    applyStimulus(1'b0, 1'b1, 3'd2, 32'hA5A5_0002, 1'b0, 3'd0, 3'd2, 3'd0);
    checkOutput("t4_hz_clr", {31'b0, bus.hazard_a}, 32'h0);

    // T5: set and clear of r4 in the same cycle keeps it pending
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 3'd0, 3'd0);
    applyStimulus(1'b0, 1'b1, 3'd4, 32'h77, 1'b1, 3'd4, 3'd4, 3'd0);
    checkOutput("t5_hz_stay", {31'b0, bus.hazard_a}, 32'h1);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd4, 3'd4);
    checkOutput("t5_rd", bus.rd_data_a, 32'h77);

    // T6: reset discards an in-flight write and mark on r6
    applyStimulus(1'b0, 1'b1, 3'd6, 32'h99, 1'b1, 3'd6, 3'd0, 3'd0);
    applyStimulus(1'b1, 1'b1, 3'd6, 32'h55, 1'b1, 3'd6, 3'd6, 3'd6);
    checkOutput("t6_hz", {31'b0, bus.hazard_a}, 32'h0);
    checkOutput("t6_rd_rst", bus.rd_data_a, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 3'd6, 3'd6);
    checkOutput("t6_rd", bus.rd_data_a, 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(31) == 0), 1'($urandom), 3'($urandom), $urandom,
                    1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
